clk_monitor: RTL and testbench

Frequency and liveness checker for the 25 MHz clock produced by the 125 MHz-referenced PLL. It runs entirely in the `clkref` domain and treats the monitored clock as an asynchronous data input. It synchronises that input, counts its rising edges over fixed reference windows and checks each count against an expected value. It reports lock, stall and sticky fault status to reset sequencing and debug logic downstream of the PLL.

---
 rtl/clk_monitor.sv | 131 +++++++++++++
 tb/tb_clk_monitor.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/clk_monitor.sv
// Frequency and liveness monitor for a PLL output clock, sampled as plain data in the clkref domain.
// Counts synchronised rising edges per fixed window and reports lock, stall and a sticky fault.
module clk_monitor #(
  parameter int WINDOW       = 1000,
  parameter int EXPECTED     = 200,
  parameter int TOL          = 2,
  parameter int GOOD_WINDOWS = 4,
  parameter int STALL_CYCLES = 16,
  parameter int CNT_W        = 16
) (
  input  logic             clkref,
  input  logic             rst_n,
  input  logic             mon_clk,
  input  logic             fault_clr,
  output logic             locked,
  output logic             stalled,
  output logic             fault,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_count,
  output logic             state_dbg
);
  localparam int WIN_W   = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam int STALL_W = $clog2(STALL_CYCLES + 1);
  localparam int RUN_W   = $clog2(GOOD_WINDOWS + 1);

  localparam logic [31:0]        LO_BOUND  = (EXPECTED > TOL) ? EXPECTED - TOL : 0;
  localparam logic [31:0]        HI_BOUND  = EXPECTED + TOL;
  localparam logic [WIN_W-1:0]   WIN_LAST  = WIN_W'(WINDOW - 1);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);
  localparam logic [RUN_W-1:0]   RUN_MAX   = RUN_W'(GOOD_WINDOWS);

  typedef enum logic {ACQUIRE = 1'b0, LOCKED = 1'b1} state_e;

  // meas_valid is a one-cycle strobe qualifying meas_count; there is no back-pressure.
  logic               sync1_q, sync2_q, dly_q;
  logic [WIN_W-1:0]   win_q, win_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d, cnt_final;
  logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [RUN_W-1:0]   good_run_q, good_run_d;
  logic [CNT_W-1:0]   meas_count_q;
  logic               meas_valid_q;
  logic               fault_q, fault_d;
  state_e             state_q, state_d;
  logic               edge_det, close_win, good, stall_now, set_fault;
  logic [31:0]        cnt_ext;

  assign edge_det  = sync2_q & ~dly_q;
  assign close_win = (win_q == WIN_LAST);
  assign win_d     = close_win ? '0 : win_q + WIN_W'(1);

  // An edge seen on the close cycle still belongs to the window being closed.
  assign cnt_final  = (edge_det && (edge_cnt_q != '1)) ? edge_cnt_q + CNT_W'(1) : edge_cnt_q;
  assign edge_cnt_d = close_win ? '0 : cnt_final;
  assign cnt_ext    = 32'(cnt_final);
  assign good       = (cnt_ext >= LO_BOUND) && (cnt_ext <= HI_BOUND);

  assign stall_cnt_d = edge_det ? '0 :
                       (stall_cnt_q == STALL_MAX) ? stall_cnt_q : stall_cnt_q + STALL_W'(1);
  assign stalled     = (stall_cnt_q == STALL_MAX);
  // Stall is acted on at the same edge the counter saturates, and held while it stays there.
  assign stall_now   = (stall_cnt_d == STALL_MAX) || stalled;

  always_comb begin
    state_d    = state_q;
    good_run_d = good_run_q;
    fault_d    = fault_q;
    set_fault  = 1'b0;
    if (close_win) begin
      if (good) good_run_d = (good_run_q == RUN_MAX) ? good_run_q : good_run_q + RUN_W'(1);
      else      good_run_d = '0;
    end
    case (state_q)
      ACQUIRE: if (close_win && good && (good_run_d == RUN_MAX)) state_d = LOCKED;
      LOCKED: begin
        if (close_win && !good) begin
          state_d   = ACQUIRE;
          set_fault = 1'b1;
        end
      end
      default: state_d = ACQUIRE;
    endcase
    if (stall_now) begin
      good_run_d = '0;
      state_d    = ACQUIRE;
      if (state_q == LOCKED) set_fault = 1'b1;
    end
    if (fault_clr) fault_d = 1'b0;
    if (set_fault) fault_d = 1'b1;
  end

  always_ff @(posedge clkref or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACQUIRE;
      good_run_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      good_run_q <= good_run_d;
      fault_q    <= fault_d;
    end
  end

  always_ff @(posedge clkref or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      dly_q        <= 1'b0;
      win_q        <= '0;
      edge_cnt_q   <= '0;
      stall_cnt_q  <= '0;
      meas_valid_q <= 1'b0;
      meas_count_q <= '0;
    end else begin
      sync1_q      <= mon_clk;
      sync2_q      <= sync1_q;
      dly_q        <= sync2_q;
      win_q        <= win_d;
      edge_cnt_q   <= edge_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      meas_valid_q <= close_win;
      if (close_win) meas_count_q <= cnt_final;
    end
  end

  assign locked     = (state_q == LOCKED);
  assign fault      = fault_q;
  assign meas_valid = meas_valid_q;
  assign meas_count = meas_count_q;
  assign state_dbg  = (state_q == LOCKED);

endmodule

// File: tb/tb_clk_monitor.sv
// Directed bench for clk_monitor: an edge-rate generator feeds mon_clk window by window and
// pushes each window's edge count to a scoreboard that is checked on every meas_valid.
module tb_clk_monitor;
  localparam int CNT_W  = 16;
  localparam int PERIOD = 8;

  logic             clkref = 1'b0;
  logic             rst_n = 1'b1;
  logic             mon_clk = 1'b0;
  logic             fault_clr = 1'b0;
  logic             locked, stalled, fault, meas_valid, state_dbg;
  logic [CNT_W-1:0] meas_count;

  logic [CNT_W-1:0] exp_q[$];
  int               rate_q[$];
  int               n_total = 0;
  int               n_pass = 0;
  time              t_ref = 0;

  int gs, acc, rate, hi_cnt;

  clk_monitor dut (
    .clkref     (clkref),
    .rst_n      (rst_n),
    .mon_clk    (mon_clk),
    .fault_clr  (fault_clr),
    .locked     (locked),
    .stalled    (stalled),
    .fault      (fault),
    .meas_valid (meas_valid),
    .meas_count (meas_count),
    .state_dbg  (state_dbg)
  );

  // clock / reset
  always #(PERIOD / 2) clkref = ~clkref;

  initial begin
    #(PERIOD * 40000);
    $display("FAIL watchdog: run exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // mon_clk generator, stepping on falling clkref edges. Each DUT window of 1000 cycles sees
  // exactly `rate` rises (phase accumulator restarted at the window start, last rise lands on
  // the close cycle). Step g reaches the DUT window offset g+3 after synchronisation.
  always @(negedge clkref) begin
    if (!rst_n) begin
      mon_clk = 1'b0;
      gs      = 0;
      rate    = 200;
      acc     = 3 * 200;
      hi_cnt  = 0;
      exp_q.delete();
      t_ref   = $time;
    end else begin
      if (gs == 0) begin
        exp_q.push_back(CNT_W'(rate));
      end else if ((gs + 3) % 1000 == 0) begin
        if (rate_q.size() > 0) rate = rate_q.pop_front();
        acc = 0;
        exp_q.push_back(CNT_W'(rate));
      end
      if (hi_cnt > 0) begin
        hi_cnt--;
        if (hi_cnt == 0) mon_clk = 1'b0;
      end
      acc += rate;
      if (acc >= 1000) begin
        acc    -= 1000;
        mon_clk = 1'b1;
        hi_cnt  = 2;
      end
      gs++;
    end
  end

  // scoreboard
  always @(negedge clkref) begin
    logic [31:0] e;
    if (rst_n && meas_valid) begin
      e = 'x;
      if (exp_q.size() > 0) e = 32'(exp_q.pop_front());
      check("meas_count", 32'(meas_count), e);
    end
  end

  // driver tasks
  task automatic wait_close(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clkref);
      n++;
    end while (!meas_valid && n < 1100);
    check({tag, "_meas_valid"}, 32'(meas_valid), 1);
  endtask

  task automatic close_check(input string tag, input logic exp_lock, input logic exp_fault);
    wait_close(tag);
    check({tag, "_locked"}, 32'(locked), 32'(exp_lock));
    check({tag, "_fault"}, 32'(fault), 32'(exp_fault));
  endtask

  task automatic pulse_fault_clr();
    @(negedge clkref);
    fault_clr = 1'b1;
    @(negedge clkref);
    fault_clr = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_locked"}, 32'(locked), 0);
    check({tag, "_stalled"}, 32'(stalled), 0);
    check({tag, "_fault"}, 32'(fault), 0);
    check({tag, "_meas_valid"}, 32'(meas_valid), 0);
    check({tag, "_meas_count"}, 32'(meas_count), 0);
  endtask

  initial begin
    // Rates of windows 1..21; window 0 always runs at 200 after a reset.
    rate_q = '{200, 200, 200, 198, 202, 197, 200, 200, 200, 203, 200,
               200, 200, 200, 160, 200, 200, 200, 200, 0, 200};
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clkref);
    check_all_zero("reset");
    @(negedge clkref);
    #1 rst_n = 1'b1;

    // nominal lock
    for (int w = 0; w < 3; w++) close_check("acquire", 1'b0, 1'b0);
    close_check("lock", 1'b1, 1'b0);
    check("lock_time", 32'(($time - t_ref) / PERIOD), 4000);

    // tolerance edges: 198 and 202 keep lock, 197 loses it
    close_check("tol_198", 1'b1, 1'b0);
    close_check("tol_202", 1'b1, 1'b0);
    close_check("tol_197", 1'b0, 1'b1);
    pulse_fault_clr();
    check("fault_clr", 32'(fault), 0);

    // 203 lands after three good windows and must clear the good run
    for (int w = 0; w < 3; w++) close_check("run_pre203", 1'b0, 1'b0);
    close_check("tol_203", 1'b0, 1'b0);
    for (int w = 0; w < 3; w++) close_check("run_post203", 1'b0, 1'b0);
    close_check("relock_203", 1'b1, 1'b0);

    // loss of lock at 160 edges, with fault_clr held on that close cycle
    repeat (999) @(negedge clkref);
    fault_clr = 1'b1;
    @(negedge clkref);
    fault_clr = 1'b0;
    check("loss_meas_valid", 32'(meas_valid), 1);
    check("loss_locked", 32'(locked), 0);
    check("loss_fault_set_wins", 32'(fault), 1);
    pulse_fault_clr();
    check("loss_fault_clr", 32'(fault), 0);

    // relock, then stall: last rise sits on the close cycle of the locked window
    for (int w = 0; w < 3; w++) close_check("relock", 1'b0, 1'b0);
    close_check("relock_done", 1'b1, 1'b0);
    repeat (15) @(negedge clkref);
    check("pre_stall_stalled", 32'(stalled), 0);
    check("pre_stall_locked", 32'(locked), 1);
    @(negedge clkref);
    check("stall_stalled", 32'(stalled), 1);
    check("stall_locked", 32'(locked), 0);
    check("stall_fault", 32'(fault), 1);
    wait_close("stall_window");
    check("stall_window_stalled", 32'(stalled), 1);
    close_check("restart", 1'b0, 1'b1);
    check("restart_stalled", 32'(stalled), 0);
    for (int w = 0; w < 2; w++) close_check("restart_acq", 1'b0, 1'b1);
    close_check("restart_lock", 1'b1, 1'b1);

    // asynchronous reset in the middle of a locked window
    repeat (500) @(negedge clkref);
    #2 rst_n = 1'b0;
    #1 check_all_zero("mid_reset");
    repeat (3) @(negedge clkref);
    #1 rst_n = 1'b1;
    close_check("post_reset", 1'b0, 1'b0);
    check("post_reset_time", 32'(($time - t_ref) / PERIOD), 1000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
